if_fetch_unit: RTL and testbench

Instruction fetch stage with an integrated IF/ID pipeline register. It sits upstream of the decode stage and is the producer of that stage's `PC_in`/`Instruction` inputs. It obeys the same `Freeze` hazard signal and accepts branch redirects from the execute stage. It drives a variable-latency instruction memory through a req/ack handshake, holds a fetched word while the pipe is frozen, and squashes wrong-path fetches.

---
 rtl/if_fetch_unit.sv | 123 ++++++++++++
 tb/tb_if_fetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register, req/ack instruction-memory
// handshake, one-word hold buffer for frozen pipes and wrong-path squashing.
//
// state | meaning
// FETCH | request outstanding at pc; IF/ID takes the word on ack
// DRAIN | wrong-path request in flight; its data is dropped, then pc <= redir
// STALL | fetched word parked in hold_buf while Freeze is high; no request
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Freeze,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] PC_out,
    output logic [31:0] Instruction,
    output logic        Valid
);

    typedef enum logic [1:0] {FETCH, DRAIN, STALL} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] redir, redir_nxt;
    logic [31:0] hold_buf, hold_nxt;
    logic [31:0] pc_out_nxt, instr_nxt;
    logic        valid_nxt;
    logic [31:0] pc_inc;

    assign pc_inc    = pc + PC_STEP;
    assign imem_req  = rst && (state != STALL);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            redir       <= '0;
            hold_buf    <= '0;
            PC_out      <= '0;
            Instruction <= '0;
            Valid       <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            redir       <= redir_nxt;
            hold_buf    <= hold_nxt;
            PC_out      <= pc_out_nxt;
            Instruction <= instr_nxt;
            Valid       <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        redir_nxt  = redir;
        hold_nxt   = hold_buf;
        pc_out_nxt = PC_out;
        instr_nxt  = Instruction;
        valid_nxt  = Valid;
        case (state)
            FETCH: begin
                if (imem_ack) begin
                    if (Branch_taken) begin
                        pc_nxt    = Branch_addr;
                        instr_nxt = '0;
                        valid_nxt = 1'b0;
                    end else if (Freeze) begin
                        hold_nxt  = imem_data;
                        state_nxt = STALL;
                    end else begin
                        pc_out_nxt = pc_inc;
                        instr_nxt  = imem_data;
                        valid_nxt  = 1'b1;
                        pc_nxt     = pc_inc;
                    end
                end else if (Branch_taken) begin
                    // pc must stay put until the in-flight request is acked
                    redir_nxt = Branch_addr;
                    instr_nxt = '0;
                    valid_nxt = 1'b0;
                    state_nxt = DRAIN;
                end else if (!Freeze) begin
                    instr_nxt = '0;
                    valid_nxt = 1'b0;
                end
            end
            DRAIN: begin
                instr_nxt = '0;
                valid_nxt = 1'b0;
                if (Branch_taken)
                    redir_nxt = Branch_addr;
                if (imem_ack) begin
                    pc_nxt    = Branch_taken ? Branch_addr : redir;
                    state_nxt = FETCH;
                end
            end
            STALL: begin
                if (Branch_taken) begin
                    pc_nxt    = Branch_addr;
                    instr_nxt = '0;
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end else if (!Freeze) begin
                    pc_out_nxt = pc_inc;
                    instr_nxt  = hold_buf;
                    valid_nxt  = 1'b1;
                    pc_nxt     = pc_inc;
                    state_nxt  = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, wait states, freeze, redirects,
// PC wrap and mid-transaction reset, with a small req/ack memory model per instance.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst, rst_w;
    logic        Freeze, Branch_taken;
    logic [31:0] Branch_addr;
    logic        auto_mem, man_ack;
    logic [31:0] man_data;
    logic [1:0]  wait1, wait_w;

    logic        imem_req, imem_ack, model_ack;
    logic [31:0] imem_addr, imem_data;
    logic [31:0] PC_out, Instruction;
    logic        Valid;
    logic [1:0]  cnt1;

    logic        req_w, ack_w, valid_w;
    logic [31:0] addr_w, pc_out_w, instr_w;
    logic [1:0]  cnt_w;

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst(rst), .Freeze(Freeze), .Branch_taken(Branch_taken),
        .Branch_addr(Branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .PC_out(PC_out),
        .Instruction(Instruction), .Valid(Valid)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_w (
        .clk(clk), .rst(rst_w), .Freeze(1'b0), .Branch_taken(1'b0),
        .Branch_addr(32'h0), .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(ack_w), .imem_data(addr_w), .PC_out(pc_out_w),
        .Instruction(instr_w), .Valid(valid_w)
    );

    // memory models: data = address, ack after waitN cycles of continuous request
    assign model_ack = imem_req && (cnt1 == wait1);
    assign imem_ack  = auto_mem ? model_ack : man_ack;
    assign imem_data = auto_mem ? imem_addr : man_data;
    assign ack_w     = req_w && (cnt_w == wait_w);

    always_ff @(posedge clk) begin
        if (!rst || !imem_req || model_ack) cnt1 <= '0;
        else                                cnt1 <= cnt1 + 2'd1;
        if (!rst_w || !req_w || ack_w)      cnt_w <= '0;
        else                                cnt_w <= cnt_w + 2'd1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 0; rst_w = 0; Freeze = 0; Branch_taken = 0; Branch_addr = 0;
        auto_mem = 1; man_ack = 0; man_data = 0; wait1 = 0; wait_w = 0;

        // reset state
        tick(); tick();
        check("rst_req",   {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, Valid}, 32'd0);
        check("rst_pcout", PC_out, 32'd0);
        check("rst_instr", Instruction, 32'd0);

        // zero-wait streaming
        rst = 1;
        #1;
        check("first_req",  {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("zw_valid", {31'b0, Valid}, 32'd1);
            check("zw_instr", Instruction, 32'(4 * k));
            check("zw_pcout", PC_out, 32'(4 * k + 4));
            check("zw_addr",  imem_addr, 32'(4 * k + 4));
        end

        // two wait cycles: Valid 0,0,1
        wait1 = 2;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 3; j++) begin
                tick();
                check("w2_valid", {31'b0, Valid}, (j == 2) ? 32'd1 : 32'd0);
                check("w2_instr", Instruction, (j == 2) ? 32'(16 + 4 * r) : 32'd0);
                check("w2_pcout", PC_out, (j == 2) ? 32'(20 + 4 * r) : 32'(16 + 4 * r));
            end
        end

        // freeze coinciding with the ack for address 24
        wait1 = 0; Freeze = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("frz_req",   {31'b0, imem_req}, 32'd0);
            check("frz_valid", {31'b0, Valid}, 32'd1);
            check("frz_instr", Instruction, 32'd20);
            check("frz_pcout", PC_out, 32'd24);
        end
        Freeze = 0;
        #1;
        check("rel_req_low", {31'b0, imem_req}, 32'd0);
        tick();
        check("rel_instr", Instruction, 32'd24);
        check("rel_pcout", PC_out, 32'd28);
        check("rel_addr",  imem_addr, 32'd28);
        check("rel_req",   {31'b0, imem_req}, 32'd1);
        tick();
        check("rel_next_instr", Instruction, 32'd28);

        // branch while a request is pending, ack two cycles later
        auto_mem = 0; man_ack = 0;
        tick();
        check("bub_valid", {31'b0, Valid}, 32'd0);
        Branch_taken = 1; Branch_addr = 32'h40;
        tick();
        Branch_taken = 0;
        check("br_valid", {31'b0, Valid}, 32'd0);
        check("br_instr", Instruction, 32'd0);
        check("br_hold_addr", imem_addr, 32'd32);
        tick();
        check("drain_addr", imem_addr, 32'd32);
        man_ack = 1; man_data = 32'hDEAD_BEEF;
        tick();
        check("drop_valid", {31'b0, Valid}, 32'd0);
        check("drop_instr", Instruction, 32'd0);
        check("tgt_addr", imem_addr, 32'h40);
        man_data = 32'h1234_5678;
        tick();
        check("tgt_instr", Instruction, 32'h1234_5678);
        check("tgt_pcout", PC_out, 32'h44);

        // branch + freeze + ack in one cycle
        Branch_taken = 1; Branch_addr = 32'h100; Freeze = 1; man_data = 32'hBAD0_0001;
        tick();
        Branch_taken = 0; Freeze = 0;
        check("bfa_valid", {31'b0, Valid}, 32'd0);
        check("bfa_instr", Instruction, 32'd0);
        check("bfa_addr", imem_addr, 32'h100);

        // branch out of STALL
        Freeze = 1; man_data = 32'hA5A5_0000;
        tick();
        check("stall_req", {31'b0, imem_req}, 32'd0);
        Branch_taken = 1; Branch_addr = 32'h200; man_ack = 0;
        tick();
        Branch_taken = 0; Freeze = 0;
        check("stbr_addr",  imem_addr, 32'h200);
        check("stbr_req",   {31'b0, imem_req}, 32'd1);
        check("stbr_valid", {31'b0, Valid}, 32'd0);

        // second redirect during DRAIN, coinciding with the ack
        Branch_taken = 1; Branch_addr = 32'h300;
        tick();
        check("dr_addr", imem_addr, 32'h200);
        Branch_addr = 32'h380; man_ack = 1; man_data = 32'hFFFF_0000;
        tick();
        Branch_taken = 0;
        check("dr2_addr", imem_addr, 32'h380);
        man_data = 32'h0BAD_F00D;
        tick();
        man_ack = 0;
        check("dr2_instr", Instruction, 32'h0BAD_F00D);
        check("dr2_pcout", PC_out, 32'h384);
        check("dr2_valid", {31'b0, Valid}, 32'd1);

        // PC wrap and mid-transaction reset
        rst_w = 1;
        #1;
        check("wr_addr0", addr_w, 32'hFFFF_FFFC);
        tick();
        check("wr_addr1", addr_w, 32'd0);
        check("wr_pcout", pc_out_w, 32'd0);
        check("wr_instr", instr_w, 32'hFFFF_FFFC);
        wait_w = 2;
        tick();
        check("wr_bubble", {31'b0, valid_w}, 32'd0);
        rst_w = 0;
        #1;
        check("wr_rst_req", {31'b0, req_w}, 32'd0);
        tick();
        check("wr_rst_valid", {31'b0, valid_w}, 32'd0);
        check("wr_rst_instr", instr_w, 32'd0);
        check("wr_rst_pcout", pc_out_w, 32'd0);
        wait_w = 0; rst_w = 1;
        #1;
        check("wr_restart", addr_w, 32'hFFFF_FFFC);
        tick();
        check("wr_restart_instr", instr_w, 32'hFFFF_FFFC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
